// File: rtl/uart_rx_engine.sv
// ---------------------------------------------------------------------------
// uart_rx_engine
//
// Receive front-end of the UART path. The block synchronizes the asynchronous
// serial line and oversamples it 16x. It qualifies the start bit and recovers
// 8N1 frames LSB-first. Each byte is handed to the RX FIFO writer through a
// level rx_avail / pulse rx_ack handshake, with framing-error and overrun
// status.
//
// Parameters
//   SYS_FREQ_HZ  system clock frequency in Hz (must be supplied)
//   BAUD_RATE    line rate in bit/s
//   DIVISOR      derived: round(SYS_FREQ_HZ / (BAUD_RATE * 16)), must be >= 2
//
// Ports
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   uart_rxd    in   asynchronous serial input, idle high
//   rx_data     out  last received byte
//   rx_avail    out  byte valid, held until acknowledged
//   rx_error    out  framing error on the presented byte (qualified by rx_avail)
//   rx_overrun  out  a byte was overwritten before it was acknowledged
//   rx_ack      in   one-cycle consume pulse from the FIFO writer
//   rx_busy     out  frame reception in progress
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_engine #(
    parameter int unsigned SYS_FREQ_HZ = 0,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    output logic       rx_overrun,
    input  logic       rx_ack,
    output logic       rx_busy
);

    localparam int unsigned     OVERSAMPLE  = 16;
    localparam longint unsigned SAMPLE_RATE = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
    // Rounded division: add half the divisor before truncating.
    localparam int unsigned     DIVISOR     = 32'((64'(SYS_FREQ_HZ) + SAMPLE_RATE / 2) / SAMPLE_RATE);
    localparam int unsigned     DIV_W       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIVISOR - 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_rx_engine: round(SYS_FREQ_HZ / (BAUD_RATE * 16)) must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t           state;
    logic             sync_1;
    logic             sync_2;
    logic             sync_prev;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       samp_cnt;
    logic             samp_7;
    logic             samp_8;
    logic             bit_maj;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic             fall_edge;
    logic             tick;
    logic             maj_now;

    assign fall_edge = sync_prev & ~sync_2;
    assign tick      = (div_cnt == DIV_LAST);
    // Majority of the samples at counts 7 and 8 and the live sample at count 9.
    assign maj_now   = (samp_7 & samp_8) | (samp_7 & sync_2) | (samp_8 & sync_2);

    // NOTE: these flops reset to the idle line level (1). A clean line raises no
    // edge at reset release, but a line held low does and is received as a break.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_1    <= uart_rxd;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    // Baud tick and oversample counter. Both restart on a start edge so sample
    // 8 falls near the middle of each bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (state == ST_IDLE && fall_edge) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            samp_cnt <= samp_cnt + 4'd1;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    // Mid-bit samples. bit_maj holds the voted bit for use at sample count 15.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            samp_7  <= 1'b1;
            samp_8  <= 1'b1;
            bit_maj <= 1'b1;
        end else if (tick) begin
            case (samp_cnt)
                4'd7:    samp_7  <= sync_2;
                4'd8:    samp_8  <= sync_2;
                4'd9:    bit_maj <= maj_now;
                default: ;
            endcase
        end
    end

    // Frame FSM and output handshake. The acknowledge clear comes first, so a
    // delivery in the same cycle overrides it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_avail   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            if (rx_ack && rx_avail) begin
                rx_avail   <= 1'b0;
                rx_error   <= 1'b0;
                rx_overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (fall_edge) begin
                        state   <= ST_START;
                        rx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (tick && samp_cnt == 4'd15) begin
                        if (bit_maj) begin
                            // Start bit did not hold low: a glitch, so drop it.
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick && samp_cnt == 4'd15) begin
                        shift_reg <= {bit_maj, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    // Finish at mid stop bit so that a back-to-back start edge
                    // is seen from IDLE.
                    if (tick && samp_cnt == 4'd9) begin
                        state      <= ST_IDLE;
                        rx_busy    <= 1'b0;
                        rx_data    <= shift_reg;
                        rx_error   <= ~maj_now;
                        rx_avail   <= 1'b1;
                        rx_overrun <= rx_avail & ~rx_ack;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_engine
//
// Self-checking bench for uart_rx_engine at 18.432 MHz / 115200 baud
// (DIVISOR = 10, 160 clocks per bit). A frame-level model tracks the expected
// rx_data / rx_avail / rx_error / rx_overrun from the handshake rules. Directed
// and $urandom frames are driven on uart_rxd and compared against that model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_engine;

    localparam int unsigned SYS_FREQ_HZ = 18_432_000;
    localparam int unsigned BAUD_RATE   = 115200;
    localparam real         BIT_NOM     = 160.0;
    localparam real         BIT_FAST    = 160.0 / 1.03;
    localparam real         BIT_SLOW    = 160.0 / 0.97;

    logic       clk;
    logic       resetn;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_overrun;
    logic       rx_ack;
    logic       rx_busy;

    uart_rx_engine #(
        .SYS_FREQ_HZ (SYS_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_avail   (rx_avail),
        .rx_error   (rx_error),
        .rx_overrun (rx_overrun),
        .rx_ack     (rx_ack),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model of the output registers.
    logic [7:0] m_data;
    logic       m_avail;
    logic       m_error;
    logic       m_overrun;

    bit         line_bits[$];
    logic [8:0] rx_q[$];
    int         lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_data    = 8'h00;
        m_avail   = 1'b0;
        m_error   = 1'b0;
        m_overrun = 1'b0;
    endfunction

    // A completed frame: it overruns an unconsumed byte unless acked that cycle.
    function automatic void model_deliver(input logic [7:0] b, input logic err, input logic acked);
        m_overrun = m_avail & ~acked;
        m_data    = b;
        m_error   = err;
        m_avail   = 1'b1;
    endfunction

    function automatic void model_ack();
        if (m_avail) begin
            m_avail   = 1'b0;
            m_error   = 1'b0;
            m_overrun = 1'b0;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".data"},    32'(rx_data),    32'(m_data));
        check({tag, ".avail"},   32'(rx_avail),   32'(m_avail));
        check({tag, ".error"},   32'(rx_error),   32'(m_error));
        check({tag, ".overrun"}, 32'(rx_overrun), 32'(m_overrun));
    endtask

    // Start bit, 8 data bits LSB first, then the given stop bit.
    function automatic void push_frame(input logic [7:0] b, input logic stop);
        line_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) line_bits.push_back(b[i]);
        line_bits.push_back(stop);
    endfunction

    // Drives the queued bits back to back. Bit edges fall at rounded multiples
    // of bit_cycles, so a non-integer bit length models a baud mismatch.
    task automatic send_line(input real bit_cycles);
        int n;
        int cyc;
        int target;
        n = line_bits.size();
        @(posedge clk);
        #1;
        cyc = 0;
        for (int j = 0; j < n; j++) begin
            uart_rxd = line_bits[j];
            target = $rtoi((j + 1) * bit_cycles + 0.5);
            while (cyc < target) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        uart_rxd = 1'b1;
        line_bits.delete();
    endtask

    // Counts clock edges from the start-bit edge until rx_avail is seen.
    task automatic measure_latency();
        @(posedge clk);
        #1;
        lat = 0;
        while (!rx_avail && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    // Holds rx_ack high across the edge `edge_no` clocks after the start-bit edge.
    task automatic ack_at(input int edge_no);
        @(posedge clk);
        #1;
        repeat (edge_no - 1) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    // Records each presented byte and acknowledges it in the following cycle.
    task automatic collect(input int want, input int budget);
        int cyc;
        cyc = 0;
        rx_q.delete();
        while (rx_q.size() < want && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rx_avail) begin
                rx_q.push_back({rx_error, rx_data});
                rx_ack = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
                rx_ack = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, observed %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b2b_bytes [3];
        real        rates [2];
        int         rise;
        int         hi;

        b2b_bytes = '{8'h00, 8'hFF, 8'h5A};
        rates     = '{BIT_FAST, BIT_SLOW};

        resetn   = 1'b0;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.busy", 32'(rx_busy), 32'd0);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single nominal frame, with the delivery latency.
        push_frame(8'h55, 1'b1);
        fork
            send_line(BIT_NOM);
            measure_latency();
        join
        check($sformatf("single.latency=%0d", lat), 32'(lat >= 1541 && lat <= 1545), 32'd1);
        model_deliver(8'h55, 1'b0, 1'b0);
        check_outputs("single");
        check("single.busy", 32'(rx_busy), 32'd0);

        pulse_ack();
        model_ack();
        check_outputs("ack");
        pulse_ack();
        model_ack();
        check_outputs("ack_idle");

        // 40-cycle glitch: a false start that lasts one bit time.
        fork
            begin
                @(posedge clk);
                #1;
                uart_rxd = 1'b0;
                repeat (40) @(posedge clk);
                #1;
                uart_rxd = 1'b1;
            end
            begin
                @(posedge clk);
                #1;
                rise = 0;
                while (!rx_busy && rise < 20) begin
                    @(posedge clk);
                    #1;
                    rise++;
                end
                hi = 0;
                while (rx_busy && hi < 400) begin
                    @(posedge clk);
                    #1;
                    hi++;
                end
            end
        join
        check("glitch.busy_rise", 32'(rise), 32'd3);
        check($sformatf("glitch.busy_len=%0d", hi), 32'(hi >= 159 && hi <= 161), 32'd1);
        repeat (200) @(posedge clk);
        #1;
        check_outputs("glitch");
        check("glitch.busy", 32'(rx_busy), 32'd0);

        // Framing error, then a break.
        push_frame(8'hA3, 1'b0);
        send_line(BIT_NOM);
        model_deliver(8'hA3, 1'b1, 1'b0);
        check_outputs("frame_err");
        pulse_ack();
        model_ack();

        for (int i = 0; i < 12; i++) line_bits.push_back(1'b0);
        send_line(BIT_NOM);
        model_deliver(8'h00, 1'b1, 1'b0);
        check_outputs("break");
        check("break.busy", 32'(rx_busy), 32'd0);
        pulse_ack();
        model_ack();
        repeat (20) @(posedge clk);
        #1;

        // Overrun, then acknowledge.
        push_frame(8'h11, 1'b1);
        send_line(BIT_NOM);
        model_deliver(8'h11, 1'b0, 1'b0);
        check_outputs("ovr_first");
        push_frame(8'h22, 1'b1);
        send_line(BIT_NOM);
        model_deliver(8'h22, 1'b0, 1'b0);
        check_outputs("ovr_second");
        pulse_ack();
        model_ack();
        check_outputs("ovr_ack");

        // Acknowledge coinciding with the next delivery.
        push_frame(8'h33, 1'b1);
        send_line(BIT_NOM);
        model_deliver(8'h33, 1'b0, 1'b0);
        check_outputs("collide_pre");
        push_frame(8'h44, 1'b1);
        fork
            send_line(BIT_NOM);
            ack_at((lat >= 2 && lat < 2000) ? lat : 1543);
        join
        model_deliver(8'h44, 1'b0, 1'b1);
        check_outputs("collide");
        pulse_ack();
        model_ack();

        // Random bytes, random stop bits and random acknowledgement.
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            push_frame(b, stop);
            send_line(BIT_NOM);
            model_deliver(b, ~stop, 1'b0);
            check_outputs($sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                model_ack();
                check_outputs($sformatf("rand%0d_ack", i));
            end
            repeat ($urandom_range(2, 30)) @(posedge clk);
            #1;
        end
        pulse_ack();
        model_ack();

        // Back-to-back frames at +3 % and -3 % baud.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) push_frame(b2b_bytes[k], 1'b1);
            fork
                send_line(rates[r]);
                collect(3, 6000);
            join
            check($sformatf("b2b%0d.count", r), 32'(rx_q.size()), 32'd3);
            for (int k = 0; k < 3; k++) begin
                if (k < rx_q.size()) begin
                    check($sformatf("b2b%0d.byte%0d", r, k), 32'(rx_q[k]), 32'({1'b0, b2b_bytes[k]}));
                end
                model_deliver(b2b_bytes[k], 1'b0, 1'b0);
                model_ack();
            end
            check_outputs($sformatf("b2b%0d_end", r));
            repeat (10) @(posedge clk);
            #1;
        end

        // Reset in the middle of a frame, with a byte pending.
        push_frame(8'h77, 1'b1);
        send_line(BIT_NOM);
        model_deliver(8'h77, 1'b0, 1'b0);
        check_outputs("rst_pre");
        push_frame(8'hFF, 1'b1);
        fork
            send_line(BIT_NOM);
            begin
                @(posedge clk);
                #1;
                repeat (720) @(posedge clk);
                #3;
                resetn = 1'b0;
                #1;
                model_reset();
                check_outputs("rst_async");
                check("rst_async.busy", 32'(rx_busy), 32'd0);
                repeat (3) @(posedge clk);
                #2;
                resetn = 1'b1;
            end
        join
        repeat (400) @(posedge clk);
        #1;
        check_outputs("rst_idle");
        check("rst_idle.busy", 32'(rx_busy), 32'd0);
        push_frame(8'hC3, 1'b1);
        send_line(BIT_NOM);
        model_deliver(8'hC3, 1'b0, 1'b0);
        check_outputs("rst_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Serial receive front-end of the UART path. It oversamples `uart_rxd`, qualifies the start bit, and recovers 8N1 frames LSB-first. Each received byte is presented to the Wishbone UART receive FIFO writer through a level `rx_avail` / pulse `rx_ack` handshake, with framing-error and overrun status. It sits directly upstream of the RX FIFO and replaces the receive half of the monolithic UART engine.

## Interface

- `SYS_FREQ_HZ`, mandatory: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: samples per bit; fixed at 16 and not overridable.
- Derived `DIVISOR` = round(SYS_FREQ_HZ / (BAUD_RATE·16)). Must be ≥ 2; elaboration fails otherwise.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.
- `uart_rxd`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  last received byte.
- `rx_avail`  out  1  byte valid; held until acknowledged.
- `rx_error`  out  1  framing error on the presented byte; qualified by `rx_avail`.
- `rx_overrun`  out  1  a byte was overwritten before acknowledge.
- `rx_ack`  in  1  one-cycle consume pulse from the FIFO writer.
- `rx_busy`  out  1  frame reception in progress.

## Operation

- **Synchronizer:** 2-FF synchronizer on `uart_rxd`, reset value 1.
- **Edge detect:** a third register holds the previous synchronized value; a falling edge is previous=1, current=0.
- **Tick generator:** counter runs 0..DIVISOR-1 and emits `tick` when it equals DIVISOR-1. It is cleared on a start edge in IDLE.
- **Sample counter:** 4 bits, advances on each `tick`. The bit sampled is the majority of samples taken at sample counts 7, 8 and 9.
- **FSM:**
  - IDLE: on a falling edge, clear the tick and sample counters and go to START.
  - START: at the tick with sample count 15, if the majority is 1 it is a false start; return to IDLE with no flags. Otherwise go to DATA with bit index 0.
  - DATA: at the tick with sample count 15, shift the majority into the MSB of an 8-bit shift register (right shift, so the byte ends LSB-first). After the 8th bit, go to STOP.
  - STOP: at the tick with sample count 9, evaluate the majority, then go to IDLE. Ending at mid-stop-bit lets the next start edge be caught.
- **Byte delivery on STOP completion (cycle after that tick):**
  - `rx_data` ← shift register.
  - `rx_error` ← ~majority.
  - `rx_avail` ← 1.
  - If `rx_avail` was already 1 with no `rx_ack` in that cycle, set `rx_overrun` ← 1. The new byte overwrites the old one.
- **Break:** a break (line low through the stop bit) delivers `rx_data`=0x00 with `rx_error`=1.
- **`rx_ack` while `rx_avail`=1:** next cycle `rx_avail`, `rx_error` and `rx_overrun` are all 0. `rx_data` holds its value.
- **Simultaneous `rx_ack` and delivery:** delivery wins. `rx_avail` stays 1 with the new byte, `rx_error` takes the new frame's value, and `rx_overrun` becomes 0.
- **`rx_ack` while `rx_avail`=0:** ignored.
- **`rx_busy`:** 1 in START, DATA and STOP; 0 in IDLE.
- **Reset (including mid-frame):**
  - `rx_data`=0x00, `rx_avail`=0, `rx_error`=0, `rx_overrun`=0, `rx_busy`=0.
  - FSM in IDLE; counters at 0; synchronizer registers at 1.
  - A line held low through reset release produces a falling edge after 2 cycles. That attempt completes as a break frame.

## Timing

- Pin to synchronized edge: 2 cycles. `rx_busy` rises 1 cycle later.
- Bit period: 16·DIVISOR cycles.
- Start pin edge to `rx_avail` rising: (9·16 + 10)·DIVISOR cycles + 3 cycles ±1.
- False start: `rx_busy` falls 1 cycle after the START evaluation tick, i.e. 16·DIVISOR cycles after it rose, ±1.
- Minimum acceptable gap between frames: zero idle (back-to-back frames).
- Baud tolerance: ±3% total mismatch must receive correctly.
- `rx_ack` to flags cleared: 1 cycle.
- All outputs are registered.

## Test plan

Common setup: SYS_FREQ_HZ=18_432_000, BAUD_RATE=115200, giving DIVISOR=10 and 160 cycles per bit.

- **Single frame:** send 0x55 → `rx_data`=0x55, `rx_avail`=1, `rx_error`=0 at 1543±2 cycles after the start edge. `rx_busy` is low afterwards.
- **Glitch rejection:** drive `uart_rxd` low for 40 cycles, then high → no `rx_avail`; `rx_busy` high ~160 cycles, then 0.
- **Framing error and break:**
  - 0xA3 with stop bit=0 → `rx_data`=0xA3, `rx_error`=1.
  - Line held low 12 bit times → `rx_data`=0x00, `rx_error`=1.
- **Overrun, ack and collision:**
  - 0x11 then 0x22 with no ack → `rx_data`=0x22, `rx_overrun`=1.
  - Pulse `rx_ack` → `rx_avail`, `rx_error`, `rx_overrun` all 0 next cycle.
  - `rx_ack` in the delivery cycle → `rx_avail` stays 1, `rx_overrun`=0.
- **Back-to-back frames with baud error:** 0x00, 0xFF, 0x5A at +3% and at −3% baud, no idle between frames → all three bytes received in order with `rx_error`=0. Each byte is acked in the cycle after its delivery.
- **Reset mid-frame:** assert `resetn` low during bit 4 of a frame → all outputs 0 asynchronously. The next clean 0xC3 frame is received correctly.
